// File: rtl/seconds_counter.sv
`default_nettype none
// ============================================================================
// Module   : seconds_counter
// Function : 1 Hz prescaler plus 24 h seconds count with start/stop/clear/load
// Revision : 1.0 - initial release
// ============================================================================
module seconds_counter #(
    parameter int CLK_FREQ    = 50000000,
    parameter int MAX_SECONDS = 86399
) (
    input  logic        CLOCK_50,
    input  logic        resetn,
    input  logic        start,
    input  logic        stop,
    input  logic        clear,
    input  logic        load,
    input  logic [31:0] load_value,
    output logic [31:0] total_seconds_elapsed,
    output logic        running,
    output logic        sec_tick,
    output logic        day_wrap
);

    localparam int                 PRESC_W    = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_FREQ - 1);
    localparam logic [31:0]        COUNT_LAST = 32'(MAX_SECONDS);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;

    logic [1:0]         state_q,    state_d;
    logic [PRESC_W-1:0] presc_q,    presc_d;
    logic [31:0]        count_q,    count_d;
    logic               running_q,  running_d;
    logic               sec_tick_q, sec_tick_d;
    logic               day_wrap_q, day_wrap_d;

    // State and datapath registers
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            presc_q    <= '0;
            count_q    <= '0;
            running_q  <= 1'b0;
            sec_tick_q <= 1'b0;
            day_wrap_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            count_q    <= count_d;
            running_q  <= running_d;
            sec_tick_q <= sec_tick_d;
            day_wrap_q <= day_wrap_d;
        end
    end

    // Only the highest-priority asserted control acts: clear > load > stop > start
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = S_IDLE;
        end else if (load) begin
            state_d = state_q;
        end else if (stop) begin
            if (state_q == S_RUN) begin
                state_d = S_PAUSE;
            end
        end else if (start && (state_q != S_RUN)) begin
            state_d = S_RUN;
        end
    end

    // The prescaler only moves while already in RUN, so the start cycle itself does not count
    always_comb begin
        presc_d    = presc_q;
        count_d    = count_q;
        sec_tick_d = 1'b0;
        day_wrap_d = 1'b0;
        running_d  = (state_d == S_RUN);
        if (clear) begin
            presc_d = '0;
            count_d = '0;
        end else if (load) begin
            presc_d = '0;
            count_d = (load_value > COUNT_LAST) ? COUNT_LAST : load_value;
        end else if (!stop && (state_q == S_RUN)) begin
            if (presc_q == PRESC_LAST) begin
                presc_d    = '0;
                sec_tick_d = 1'b1;
                if (count_q >= COUNT_LAST) begin
                    count_d    = '0;
                    day_wrap_d = 1'b1;
                end else begin
                    count_d = count_q + 32'd1;
                end
            end else begin
                presc_d = presc_q + PRESC_W'(1);
            end
        end
    end

    always_comb begin
        total_seconds_elapsed = count_q;
        running               = running_q;
        sec_tick              = sec_tick_q;
        day_wrap              = day_wrap_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_seconds_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_seconds_counter
// Function : Randomized and directed bench for seconds_counter vs a seconds model
// Revision : 1.0 - initial release
// ============================================================================
module tb_seconds_counter;

    localparam int CLK_FREQ    = 4;
    localparam int MAX_SECONDS = 86399;

    logic        CLOCK_50   = 1'b0;
    logic        resetn     = 1'b1;
    logic        start      = 1'b0;
    logic        stop       = 1'b0;
    logic        clear      = 1'b0;
    logic        load       = 1'b0;
    logic [31:0] load_value = '0;
    logic [31:0] total_seconds_elapsed;
    logic        running;
    logic        sec_tick;
    logic        day_wrap;

    int errors = 0;
    int checks = 0;

    // Reference model: mode 0=idle 1=run 2=pause; phase counts cycles into the current second
    int          m_mode;
    int          m_phase;
    int unsigned m_secs;
    bit          m_tick;
    bit          m_wrap;

    seconds_counter #(
        .CLK_FREQ   (CLK_FREQ),
        .MAX_SECONDS(MAX_SECONDS)
    ) dut (
        .CLOCK_50             (CLOCK_50),
        .resetn               (resetn),
        .start                (start),
        .stop                 (stop),
        .clear                (clear),
        .load                 (load),
        .load_value           (load_value),
        .total_seconds_elapsed(total_seconds_elapsed),
        .running              (running),
        .sec_tick             (sec_tick),
        .day_wrap             (day_wrap)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic model_reset();
        m_mode  = 0;
        m_phase = 0;
        m_secs  = 0;
        m_tick  = 0;
        m_wrap  = 0;
    endtask

    // Drive one cycle of controls, advance the model at the edge, sample point is edge+1
    task automatic cycle(input bit st, input bit sp, input bit cl, input bit ld, input logic [31:0] lv);
        start = st; stop = sp; clear = cl; load = ld; load_value = lv;
        @(posedge CLOCK_50);
        m_tick = 0;
        m_wrap = 0;
        if (cl) begin
            m_mode = 0; m_phase = 0; m_secs = 0;
        end else if (ld) begin
            m_secs  = (lv > 32'(MAX_SECONDS)) ? MAX_SECONDS : lv;
            m_phase = 0;
        end else if (sp) begin
            if (m_mode == 1) m_mode = 2;
        end else if (m_mode == 1) begin
            m_phase++;
            if (m_phase == CLK_FREQ) begin
                m_phase = 0;
                m_tick  = 1;
                m_wrap  = (m_secs == MAX_SECONDS);
                m_secs  = (m_secs + 1) % (MAX_SECONDS + 1);
            end
        end else if (st) begin
            m_mode = 1;
        end
        #1;
        start = 0; stop = 0; clear = 0; load = 0; load_value = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(0, 0, 0, 0, 32'd0);
    endtask

    task automatic test_reset();
        #2 resetn = 1'b0;
        repeat (2) @(posedge CLOCK_50);
        #1;
        checks++;
        if ({total_seconds_elapsed, running, sec_tick, day_wrap} !== 35'd0) begin
            errors++;
            $display("FAIL reset_state: got cnt=%0d run=%0b tick=%0b wrap=%0b, expected all 0",
                     total_seconds_elapsed, running, sec_tick, day_wrap);
        end
        #2 resetn = 1'b1;
        model_reset();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic test_start_count();
        cycle(1, 0, 0, 0, 32'd0);
        checks++;
        if (running !== 1'b1 || total_seconds_elapsed !== 32'd0) begin
            errors++;
            $display("FAIL start_running: got run=%0b cnt=%0d, expected run=1 cnt=0", running, total_seconds_elapsed);
        end
        for (int i = 1; i <= 12; i++) begin
            idle(1);
            checks++;
            if ({total_seconds_elapsed, running, sec_tick, day_wrap} !== {m_secs, (m_mode == 1), m_tick, m_wrap}) begin
                errors++;
                $display("FAIL start_count[%0d]: got cnt=%0d run=%0b tick=%0b wrap=%0b, expected cnt=%0d run=%0b tick=%0b wrap=%0b",
                         i, total_seconds_elapsed, running, sec_tick, day_wrap, m_secs, (m_mode == 1), m_tick, m_wrap);
            end
            if (i == 4 || i == 12) begin
                checks++;
                if (total_seconds_elapsed !== 32'(i / 4) || sec_tick !== 1'b1) begin
                    errors++;
                    $display("FAIL first_ticks[%0d]: got cnt=%0d tick=%0b, expected cnt=%0d tick=1",
                             i, total_seconds_elapsed, sec_tick, i / 4);
                end
            end
        end
    endtask

    task automatic test_pause_resume();
        cycle(0, 0, 1, 0, 32'd0);
        cycle(1, 0, 0, 0, 32'd0);
        idle(6);
        checks++;
        if (total_seconds_elapsed !== 32'd1) begin
            errors++;
            $display("FAIL pause_pre: got cnt=%0d, expected 1", total_seconds_elapsed);
        end
        cycle(0, 1, 0, 0, 32'd0);
        for (int i = 0; i < 10; i++) begin
            idle(1);
            checks++;
            if (total_seconds_elapsed !== 32'd1 || running !== 1'b0 || sec_tick !== 1'b0) begin
                errors++;
                $display("FAIL pause_hold[%0d]: got cnt=%0d run=%0b tick=%0b, expected cnt=1 run=0 tick=0",
                         i, total_seconds_elapsed, running, sec_tick);
            end
        end
        cycle(1, 0, 0, 0, 32'd0);
        idle(1);
        checks++;
        if (total_seconds_elapsed !== 32'd1 || running !== 1'b1) begin
            errors++;
            $display("FAIL resume_early: got cnt=%0d run=%0b, expected cnt=1 run=1", total_seconds_elapsed, running);
        end
        idle(1);
        checks++;
        if (total_seconds_elapsed !== 32'd2 || sec_tick !== 1'b1) begin
            errors++;
            $display("FAIL resume_tick: got cnt=%0d tick=%0b, expected cnt=2 tick=1", total_seconds_elapsed, sec_tick);
        end
    endtask

    task automatic test_wrap();
        int nt = 0;
        cycle(0, 0, 0, 1, 32'd86398);
        checks++;
        if (total_seconds_elapsed !== 32'd86398 || sec_tick !== 1'b0 || running !== 1'b1) begin
            errors++;
            $display("FAIL wrap_load: got cnt=%0d tick=%0b run=%0b, expected cnt=86398 tick=0 run=1",
                     total_seconds_elapsed, sec_tick, running);
        end
        for (int i = 0; i < 3 * CLK_FREQ && nt < 2; i++) begin
            idle(1);
            if (sec_tick === 1'b1) begin
                nt++;
                checks++;
                if ((nt == 1 && (total_seconds_elapsed !== 32'd86399 || day_wrap !== 1'b0)) ||
                    (nt == 2 && (total_seconds_elapsed !== 32'd0 || day_wrap !== 1'b1))) begin
                    errors++;
                    $display("FAIL wrap_tick%0d: got cnt=%0d wrap=%0b, expected cnt=%0d wrap=%0b",
                             nt, total_seconds_elapsed, day_wrap, (nt == 1) ? 86399 : 0, nt == 2);
                end
            end
        end
        checks++;
        if (nt < 2) begin
            errors++;
            $display("FAIL wrap_timeout: got %0d ticks, expected 2", nt);
        end
    endtask

    task automatic test_load_saturate_clear();
        cycle(0, 0, 0, 1, 32'd100000);
        checks++;
        if (total_seconds_elapsed !== 32'd86399 || sec_tick !== 1'b0 || day_wrap !== 1'b0) begin
            errors++;
            $display("FAIL load_saturate: got cnt=%0d tick=%0b wrap=%0b, expected cnt=86399 tick=0 wrap=0",
                     total_seconds_elapsed, sec_tick, day_wrap);
        end
        cycle(1, 0, 1, 1, 32'd0);
        idle(5);
        checks++;
        if (total_seconds_elapsed !== 32'd0 || running !== 1'b0) begin
            errors++;
            $display("FAIL clear_load: got cnt=%0d run=%0b, expected cnt=0 run=0", total_seconds_elapsed, running);
        end
    endtask

    task automatic test_simultaneous();
        cycle(1, 0, 0, 0, 32'd0);
        cycle(0, 0, 0, 1, 32'd500);
        cycle(1, 1, 0, 0, 32'd0);
        idle(3);
        checks++;
        if (running !== 1'b0 || total_seconds_elapsed !== 32'd500) begin
            errors++;
            $display("FAIL start_stop: got run=%0b cnt=%0d, expected run=0 cnt=500", running, total_seconds_elapsed);
        end
        cycle(1, 0, 1, 0, 32'd0);
        idle(6);
        checks++;
        if (running !== 1'b0 || total_seconds_elapsed !== 32'd0) begin
            errors++;
            $display("FAIL clear_start: got run=%0b cnt=%0d, expected run=0 cnt=0", running, total_seconds_elapsed);
        end
    endtask

    task automatic test_async_reset();
        cycle(0, 0, 1, 0, 32'd0);
        cycle(0, 0, 0, 1, 32'd56);
        cycle(1, 0, 0, 0, 32'd0);
        idle(4);
        checks++;
        if (total_seconds_elapsed !== 32'd57 || sec_tick !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: got cnt=%0d tick=%0b, expected cnt=57 tick=1", total_seconds_elapsed, sec_tick);
        end
        #2 resetn = 1'b0;
        #1;
        checks++;
        if ({total_seconds_elapsed, running, sec_tick, day_wrap} !== 35'd0) begin
            errors++;
            $display("FAIL async_reset: got cnt=%0d run=%0b tick=%0b wrap=%0b, expected all 0",
                     total_seconds_elapsed, running, sec_tick, day_wrap);
        end
        start = 1'b1;
        repeat (2) @(posedge CLOCK_50);
        #1;
        checks++;
        if ({total_seconds_elapsed, running, sec_tick, day_wrap} !== 35'd0) begin
            errors++;
            $display("FAIL reset_held: got cnt=%0d run=%0b tick=%0b wrap=%0b, expected all 0",
                     total_seconds_elapsed, running, sec_tick, day_wrap);
        end
        start = 1'b0;
        #2 resetn = 1'b1;
        model_reset();
        idle(8);
        checks++;
        if (total_seconds_elapsed !== 32'd0 || running !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: got cnt=%0d run=%0b, expected cnt=0 run=0", total_seconds_elapsed, running);
        end
        cycle(1, 0, 0, 0, 32'd0);
        idle(4);
        checks++;
        if (total_seconds_elapsed !== 32'd1) begin
            errors++;
            $display("FAIL post_reset_start: got cnt=%0d, expected 1", total_seconds_elapsed);
        end
    endtask

    task automatic test_random();
        logic [31:0] lv;
        bit st, sp, cl, ld;
        for (int i = 0; i < 800; i++) begin
            st = ($urandom_range(0, 5) == 0);
            sp = ($urandom_range(0, 14) == 0);
            cl = ($urandom_range(0, 60) == 0);
            ld = ($urandom_range(0, 25) == 0);
            case ($urandom_range(0, 2))
                0:       lv = 32'(MAX_SECONDS - 3) + $urandom_range(0, 5);
                1:       lv = $urandom;
                default: lv = $urandom_range(0, MAX_SECONDS);
            endcase
            cycle(st, sp, cl, ld, lv);
            checks++;
            if ({total_seconds_elapsed, running, sec_tick, day_wrap} !== {m_secs, (m_mode == 1), m_tick, m_wrap}) begin
                errors++;
                $display("FAIL random[%0d]: got cnt=%0d run=%0b tick=%0b wrap=%0b, expected cnt=%0d run=%0b tick=%0b wrap=%0b",
                         i, total_seconds_elapsed, running, sec_tick, day_wrap, m_secs, (m_mode == 1), m_tick, m_wrap);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_start_count();
        test_pause_resume();
        test_wrap();
        test_load_saturate_clear();
        test_simultaneous();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
